// File: rtl/pmp_cfg_regfile.sv
// pmp_cfg_regfile: IO-PMP programming register file holding pmpaddr/pmpcfg state and driving per-entry match config.
// Ports: clk_i/rst_ni (async active-low reset); req_i/we_i/addr_i/wdata_i -> gnt_o, then rvalid_o/rdata_o/err_o one cycle
//   after grant; conf_addr_o/conf_mode_o/conf_access_o are the active per-entry pmpaddr, A field and {X,W,R}.
// Register map (64-bit words): [0,N) pmpaddr, [N,N+NCFG) pmpcfg words, N+NCFG COMMIT; anything else errors.
// A field encoding on conf_mode_o: 0=OFF 1=TOR 2=NA4 3=NAPOT.
// Macro PMP_CFG_SHADOW_EN: bus writes land in a shadow copy that COMMIT (bit0=1) copies to the active state.
module pmp_cfg_regfile #(
  parameter int NR_ENTRIES = 16,
  parameter int PMP_LEN    = 54,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  req_i,
  input  logic                                  we_i,
  input  logic [ADDR_WIDTH-1:0]                 addr_i,
  input  logic [DATA_WIDTH-1:0]                 wdata_i,
  output logic                                  gnt_o,
  output logic                                  rvalid_o,
  output logic [DATA_WIDTH-1:0]                 rdata_o,
  output logic                                  err_o,
  output logic [NR_ENTRIES-1:0][PMP_LEN-1:0]    conf_addr_o,
  output logic [NR_ENTRIES-1:0][1:0]            conf_mode_o,
  output logic [NR_ENTRIES-1:0][2:0]            conf_access_o
);
  localparam int NCFG = (NR_ENTRIES + 7) / 8;
  localparam int COMMIT_IDX = NR_ENTRIES + NCFG;
  localparam logic [1:0] A_TOR = 2'b01;
  logic [NR_ENTRIES-1:0][PMP_LEN-1:0] addr_q, addr_r, addr_w;
  logic [NR_ENTRIES-1:0][7:0] cfg_q, cfg_r, cfg_w;
  logic [NR_ENTRIES:0] tor_lk;
  logic [31:0] idx;
  logic [DATA_WIDTH-1:0] rd;
  logic acc, wr, err_d, unused_bits;
  // R=0,W=1 collapses to no access; reserved bits 6:5 are never stored
  function automatic logic [7:0] warl(input logic [7:0] b);
    return {b[7], 2'b00, b[4:3], b[2], b[1] & b[0], b[0]};
  endfunction
  assign idx = 32'(addr_i[ADDR_WIDTH-1:3]);
  assign err_d = (addr_i[2:0] != 3'b000) || idx > 32'(COMMIT_IDX);
  assign acc = req_i & gnt_o;
  assign wr = acc & we_i & ~err_d;
`ifdef PMP_CFG_SHADOW_EN
  logic [NR_ENTRIES-1:0][PMP_LEN-1:0] addr_s;
  logic [NR_ENTRIES-1:0][7:0] cfg_s;
  logic commit_q;
  // the bus is stalled for the single cycle in which shadow is copied to active
  assign gnt_o = req_i & rst_ni & ~commit_q;
  assign addr_r = addr_s;
  assign cfg_r = cfg_s;
  assign unused_bits = ^{wdata_i, cfg_q};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_s <= '0;
      cfg_s <= '0;
      addr_q <= '0;
      cfg_q <= '0;
      commit_q <= 1'b0;
    end else begin
      addr_s <= addr_w;
      cfg_s <= cfg_w;
      commit_q <= wr && idx == 32'(COMMIT_IDX) && wdata_i[0];
      if (commit_q) begin
        addr_q <= addr_s;
        cfg_q <= cfg_s;
      end
    end
  end
`else
  assign gnt_o = req_i & rst_ni;
  assign addr_r = addr_q;
  assign cfg_r = cfg_q;
  assign unused_bits = ^wdata_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      cfg_q <= '0;
    end else begin
      addr_q <= addr_w;
      cfg_q <= cfg_w;
    end
  end
`endif
  // lock decisions always use the active L bits; a locked TOR entry also freezes the pmpaddr below it
  always_comb begin
    addr_w = addr_r;
    cfg_w = cfg_r;
    tor_lk = '0;
    for (int i = 0; i < NR_ENTRIES; i++) tor_lk[i] = cfg_q[i][7] && cfg_q[i][4:3] == A_TOR;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (wr && idx == 32'(i) && !cfg_q[i][7] && !tor_lk[i+1]) addr_w[i] = wdata_i[PMP_LEN-1:0];
      if (wr && idx == 32'(NR_ENTRIES + i / 8) && !cfg_q[i][7]) cfg_w[i] = warl(wdata_i[8*(i%8) +: 8]);
    end
  end
  always_comb begin
    rd = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (idx == 32'(i)) rd = DATA_WIDTH'(addr_r[i]);
      if (idx == 32'(NR_ENTRIES + i / 8)) rd[8*(i%8) +: 8] = cfg_r[i];
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o <= '0;
      err_o <= 1'b0;
    end else begin
      rvalid_o <= acc;
      rdata_o <= (acc && !we_i && !err_d) ? rd : '0;
      err_o <= acc && err_d;
    end
  end
  assign conf_addr_o = addr_q;
  for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_conf
    assign conf_mode_o[g] = cfg_q[g][4:3];
    assign conf_access_o[g] = cfg_q[g][2:0];
  end
endmodule
